float_div_16bit_seq: RTL and testbench



---
 rtl/float_div_16bit_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_float_div_16bit_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_div_16bit_seq.sv
// Sequential half-precision divider: restoring significand division with valid/ready on both sides.
// Optional `flags` output and its registers are built only when FPU_DIV_FLAGS_EN is defined.

package fpu_types_pkg;
    localparam int HALF_FLOAT_W    = 16;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;
endpackage

module float_div_16bit_seq
    import fpu_types_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [HALF_FLOAT_W-1:0] dividend,
    input  logic [HALF_FLOAT_W-1:0] divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HALF_FLOAT_W-1:0] quotient
`ifdef FPU_DIV_FLAGS_EN
    ,
    output logic [3:0]              flags
`endif
);

    localparam int SIGN_BIT = HALF_FLOAT_W - 1;
    localparam int EXP_LSB  = HALF_FRACTION_W;
    localparam int MANT_W   = HALF_FRACTION_W + 1;
    localparam int REM_W    = MANT_W + 1;
    localparam int STEPS    = REM_W / BITS_PER_CYCLE;
    localparam int CNT_W    = $clog2(REM_W);

    localparam logic [HALF_FLOAT_W-1:0] QNAN_VAL = 16'hFFFF;
    localparam logic [HALF_FLOAT_W-1:0] SNAN_VAL = 16'hFDFF;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       sign_q, sign_d;
    logic [HALF_EXPONENT_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [HALF_FRACTION_W-1:0] dm_q, dm_d;
    logic [REM_W-1:0]           rem_q, rem_d, quo_q, quo_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [HALF_FLOAT_W-1:0]    quot_q, quot_d;

    // Operand classification; subnormals (exp=0) are treated as zero.
    logic [HALF_FLOAT_W-1:0] op [2];
    logic [1:0] is_max, is_zero, is_inf, is_qnan, is_snan;

    assign op[0] = dividend;
    assign op[1] = divisor;

    for (genvar gi = 0; gi < 2; gi++) begin : g_class
        assign is_max[gi]  = &op[gi][SIGN_BIT-1:EXP_LSB];
        assign is_zero[gi] = ~|op[gi][SIGN_BIT-1:EXP_LSB];
        assign is_inf[gi]  = is_max[gi] & ~|op[gi][HALF_FRACTION_W-1:0];
        assign is_qnan[gi] = is_max[gi] & op[gi][HALF_FRACTION_W-1];
        assign is_snan[gi] = is_max[gi] & ~op[gi][HALF_FRACTION_W-1]
                           & |op[gi][HALF_FRACTION_W-2:0];
    end

    logic                    in_sign;
    logic                    a_fin;
    logic                    is_special;
    logic [HALF_FLOAT_W-1:0] spec_val;
`ifdef FPU_DIV_FLAGS_EN
    logic [3:0]              spec_flags;
`endif

    assign in_sign = dividend[SIGN_BIT] ^ divisor[SIGN_BIT];
    assign a_fin   = ~is_max[0] & ~is_zero[0];

    always_comb begin
        is_special = 1'b1;
        spec_val   = '0;
`ifdef FPU_DIV_FLAGS_EN
        spec_flags = 4'b0000;
`endif
        if ((|is_qnan) || (&is_zero) || (&is_inf)) begin
            spec_val = QNAN_VAL;
`ifdef FPU_DIV_FLAGS_EN
            spec_flags = 4'b1000;
`endif
        end else if (|is_snan) begin
            spec_val = SNAN_VAL;
`ifdef FPU_DIV_FLAGS_EN
            spec_flags = 4'b1000;
`endif
        end else if (a_fin && is_zero[1]) begin
            spec_val = {in_sign, {HALF_EXPONENT_W{1'b1}}, {HALF_FRACTION_W{1'b0}}};
`ifdef FPU_DIV_FLAGS_EN
            spec_flags = 4'b0100;
`endif
        end else if (is_inf[0]) begin
            spec_val = {in_sign, {HALF_EXPONENT_W{1'b1}}, {HALF_FRACTION_W{1'b0}}};
        end else if (is_zero[0] || is_inf[1]) begin
            spec_val = '0;
        end else begin
            is_special = 1'b0;
        end
    end

    // Unrolled restoring steps; quotient bits shift in MSB-first.
    logic [MANT_W-1:0] div_m;
    logic [REM_W-1:0]  rem_chain [BITS_PER_CYCLE+1];
    logic [REM_W-1:0]  quo_chain [BITS_PER_CYCLE+1];

    assign div_m        = {1'b1, dm_q};
    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        logic ge;
        assign ge = rem_chain[gi] >= {1'b0, div_m};
        assign rem_chain[gi+1] = (ge ? rem_chain[gi] - {1'b0, div_m} : rem_chain[gi]) << 1;
        assign quo_chain[gi+1] = {quo_chain[gi][REM_W-2:0], ge};
    end

    // Normalisation: the significand ratio lies in (0.5, 2), so at most one shift.
    logic signed [6:0]          exp_raw, exp_adj;
    logic [HALF_FRACTION_W-1:0] frac_n;
    logic                       ovf, unf;
    logic [HALF_FLOAT_W-1:0]    norm_val;

    always_comb begin
        exp_raw  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 7'sd15;
        exp_adj  = quo_q[REM_W-1] ? exp_raw : exp_raw - 7'sd1;
        frac_n   = quo_q[REM_W-1] ? quo_q[REM_W-2:1] : quo_q[REM_W-3:0];
        ovf      = exp_adj >= 7'sd31;
        unf      = exp_adj <= 7'sd0;
        norm_val = {sign_q, exp_adj[HALF_EXPONENT_W-1:0], frac_n};
        if (ovf) begin
            norm_val = SNAN_VAL;
        end else if (unf) begin
            norm_val = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        dm_d    = dm_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    ea_d   = dividend[SIGN_BIT-1:EXP_LSB];
                    eb_d   = divisor[SIGN_BIT-1:EXP_LSB];
                    dm_d   = divisor[HALF_FRACTION_W-1:0];
                    rem_d  = {1'b0, 1'b1, dividend[HALF_FRACTION_W-1:0]};
                    quo_d  = '0;
                    cnt_d  = CNT_W'(STEPS - 1);
                    if (is_special) begin
                        quot_d  = spec_val;
                        state_d = DONE;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                quo_d = quo_chain[BITS_PER_CYCLE];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                quot_d  = norm_val;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            dm_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            dm_q    <= dm_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;

`ifdef FPU_DIV_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (state_q == IDLE && in_valid) begin
            flags_d = is_special ? spec_flags : 4'b0000;
        end else if (state_q == NORM) begin
            flags_d = {2'b00, ovf, unf};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_float_div_16bit_seq.sv
// Scoreboard bench for float_div_16bit_seq: instance 0 at one quotient bit per cycle, instance 1 at four.
// Flag checks are compiled in only when FPU_DIV_FLAGS_EN is defined.

module tb_float_div_16bit_seq;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DBZ  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] dividend  [2];
    logic [15:0] divisor   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] quotient  [2];
`ifdef FPU_DIV_FLAGS_EN
    logic [3:0]  flags     [2];
`endif

    initial forever #5 clk = ~clk;

    float_div_16bit_seq #(.BITS_PER_CYCLE(1)) dut1 (
        .CLK(clk), .RST(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .dividend(dividend[0]), .divisor(divisor[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .quotient(quotient[0])
`ifdef FPU_DIV_FLAGS_EN
        , .flags(flags[0])
`endif
    );

    float_div_16bit_seq #(.BITS_PER_CYCLE(4)) dut4 (
        .CLK(clk), .RST(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .dividend(dividend[1]), .divisor(divisor[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .quotient(quotient[1])
`ifdef FPU_DIV_FLAGS_EN
        , .flags(flags[1])
`endif
    );

    typedef struct {
        logic [15:0] q;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t cur [2];
    logic prev_valid [2] = '{1'b0, 1'b0};
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on each new result, then holds it to check stability under backpressure.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (out_valid[d] && !prev_valid[d]) begin
                have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                check("scoreboard_nonempty", 32'(have), 32'd1);
                if (have) begin
                    if (d == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    $display("txn dut%0d: quotient=%04h expected=%04h latency=%0d expected=%0d",
                             d, quotient[d], e.q, cyc - e.acc, e.lat);
                    check("quotient", 32'(quotient[d]), 32'(e.q));
                    check("latency", cyc - e.acc, e.lat);
`ifdef FPU_DIV_FLAGS_EN
                    check("flags", 32'(flags[d]), 32'(e.f));
`endif
                    cur[d] <= e;
                end
            end else if (out_valid[d]) begin
                check("quotient_stable", 32'(quotient[d]), 32'(cur[d].q));
                check("in_ready_low_in_done", 32'(in_ready[d]), 32'd0);
            end
            prev_valid[d] <= out_valid[d];
        end
    end

    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [3:0] ef, input int lat, input bit push);
        exp_t e;
        int   n = 0;
        dividend[d] = a;
        divisor[d]  = b;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(in_ready[d]), 32'd1);
        e.q = eq; e.f = ef; e.lat = lat; e.acc = cyc;
        if (push) begin
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (!(in_ready[d] && !out_valid[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(in_ready[d]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [3:0] ef, input int lat);
        issue(d, a, b, eq, ef, lat, 1'b1);
        wait_idle(d);
    endtask

    task automatic check_reset_state(input int d);
        check("reset_out_valid", 32'(out_valid[d]), 32'd0);
        check("reset_quotient", 32'(quotient[d]), 32'h0000);
        check("reset_in_ready", 32'(in_ready[d]), 32'd1);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            dividend[d] = '0; divisor[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_reset_state(0);
        check_reset_state(1);

        // Normal and special vectors, one bit per cycle.
        run(0, 16'h4200, 16'h4000, 16'h3E00, F_NONE, 14);
        run(0, 16'h3C00, 16'h4200, 16'h3555, F_NONE, 14);
        run(0, 16'h4000, 16'h4200, 16'h3955, F_NONE, 14);
        run(0, 16'h4500, 16'h3C00, 16'h4500, F_NONE, 14);
        run(0, 16'hC200, 16'h4000, 16'hBE00, F_NONE, 14);
        run(0, 16'h3C00, 16'h0000, 16'h7C00, F_DBZ,  1);
        run(0, 16'hBC00, 16'h0000, 16'hFC00, F_DBZ,  1);
        run(0, 16'h0000, 16'h0000, 16'hFFFF, F_INV,  1);
        run(0, 16'h7E00, 16'h3C00, 16'hFFFF, F_INV,  1);
        run(0, 16'h7D00, 16'h3C00, 16'hFDFF, F_INV,  1);
        run(0, 16'hFC00, 16'h3C00, 16'hFC00, F_NONE, 1);
        run(0, 16'h3C00, 16'h7C00, 16'h0000, F_NONE, 1);
        run(0, 16'h7BFF, 16'h0400, 16'hFDFF, F_OVF,  14);
        run(0, 16'h0400, 16'h7BFF, 16'h0000, F_UNF,  14);
        run(0, 16'h8001, 16'h3C00, 16'h0000, F_NONE, 1);

        // Backpressure: result must hold while out_ready is low.
        out_ready[0] = 1'b0;
        issue(0, 16'h4200, 16'h4000, 16'h3E00, F_NONE, 14, 1'b1);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("backpressure_valid_timeout", 32'(out_valid[0]), 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(out_valid[0]), 32'd0);
        check("drain_in_ready", 32'(in_ready[0]), 32'd1);

        // Reset in the fifth DIVIDE cycle discards the operation.
        issue(0, 16'h3C00, 16'h4200, 16'h0000, F_NONE, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check_reset_state(0);
        run(0, 16'h4400, 16'h4000, 16'h4000, F_NONE, 14);

        // Reset wins over a simultaneous in_valid.
        dividend[0] = 16'h3C00;
        divisor[0]  = 16'h0000;
        in_valid[0] = 1'b1;
        rst[0]      = 1'b1;
        @(posedge clk);
        #1;
        rst[0]      = 1'b0;
        in_valid[0] = 1'b0;
        check("rst_in_valid_no_accept", 32'(out_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        check("rst_in_valid_still_idle", 32'(out_valid[0]), 32'd0);

        // Four bits per cycle.
        run(1, 16'h4200, 16'h4000, 16'h3E00, F_NONE, 5);
        run(1, 16'h3C00, 16'h4200, 16'h3555, F_NONE, 5);
        run(1, 16'h7BFF, 16'h0400, 16'hFDFF, F_OVF,  5);
        run(1, 16'h3C00, 16'h0000, 16'h7C00, F_DBZ,  1);
        issue(1, 16'h3C00, 16'h4200, 16'h0000, F_NONE, 0, 1'b0);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        check_reset_state(1);
        run(1, 16'h4400, 16'h4000, 16'h4000, F_NONE, 5);

        repeat (3) @(posedge clk);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
